// File: rtl/result_demux.sv
// Two-way result demultiplexer: steers each accepted word by in_sel into one of two
// independent FIFOs. Optional per-output handshake counters via RESULT_DEMUX_STATS_EN.
module result_demux #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef RESULT_DEMUX_STATS_EN
    output logic [15:0]                stat0_xfers,
    output logic [15:0]                stat1_xfers,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_sel,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [WIDTH-1:0]           out0_data,
    output logic [$clog2(DEPTH):0]     out0_count,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [WIDTH-1:0]           out1_data,
    output logic [$clog2(DEPTH):0]     out1_count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [1:0]       out_ready;
    logic [1:0]       nempty;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;

    logic [WIDTH-1:0] mem_q  [2][DEPTH];
    logic [PtrW-1:0]  wptr_q [2];
    logic [PtrW-1:0]  rptr_q [2];
    logic [CntW-1:0]  cnt_q  [2];

    assign out_ready = {out1_ready, out0_ready};

    always_comb begin
        nempty = '0;
        full   = '0;
        for (int i = 0; i < 2; i++) begin
            nempty[i] = (cnt_q[i] != '0);
            full[i]   = (cnt_q[i] == CntW'(DEPTH));
        end
    end

    // Ready looks only at the selected FIFO's occupancy; a same-cycle pop never frees a slot.
    always_comb begin
        in_ready = !full[in_sel];
        push[0]  = in_valid && in_ready && !in_sel;
        push[1]  = in_valid && in_ready && in_sel;
        pop      = nempty & out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wptr_q[i] <= wptr_q[i] + PtrW'(1);
                end
                if (pop[i]) begin
                    rptr_q[i] <= rptr_q[i] + PtrW'(1);
                end
                if (push[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + CntW'(1);
                end else if (!push[i] && pop[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntW'(1);
                end
            end
        end
    end

    // Storage is not reset; valid gating hides stale entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem_q[i][wptr_q[i]] <= in_data;
            end
        end
    end

    always_comb begin
        out0_valid = nempty[0];
        out1_valid = nempty[1];
        out0_data  = nempty[0] ? mem_q[0][rptr_q[0]] : '0;
        out1_data  = nempty[1] ? mem_q[1][rptr_q[1]] : '0;
        out0_count = cnt_q[0];
        out1_count = cnt_q[1];
    end

`ifdef RESULT_DEMUX_STATS_EN
    logic [15:0] stat_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q[0] <= '0;
            stat_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pop[i] && (stat_q[i] != 16'hFFFF)) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    assign stat0_xfers = stat_q[0];
    assign stat1_xfers = stat_q[1];
`endif

endmodule
